cbd_sampler: RTL and testbench

//  Centred-binomial (CBD_eta) sampler for ML-KEM. Consumes the PRF/SHAKE output stream
//  and builds one 256-coefficient poly_t. Sits directly upstream of the linear-operation

---
 rtl/cbd_sampler.sv | 124 ++++++++++++
 tb/tb_cbd_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cbd_sampler.sv
// rtl/cbd_sampler.sv - centred-binomial coefficient sampler fed by a PRF word stream
module cbd_sampler #(
    parameter int ETA    = 2,
    parameter int WORD_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [WORD_W-1:0]    word_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    output logic [255:0][11:0]   poly_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW     = 2 * ETA;
    localparam int NWORDS = 256 * CW / WORD_W;
    localparam int BUF_W  = 2 * WORD_W;
    localparam int FILL_W = $clog2(BUF_W) + 1;
    localparam int WCNT_W = $clog2(NWORDS + 1);

    typedef enum logic {S_IDLE, S_SAMPLE} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]          ccnt_q, ccnt_d;
    logic [255:0][11:0]  poly_q, poly_d;
    logic                done_q, done_d;

    logic                consume;
    logic                accept;
    logic [BUF_W-1:0]    buf_shift;
    logic [FILL_W-1:0]   fill_base;
    logic [11:0]         a_cnt, b_cnt, coef;

    assign consume      = (state_q == S_SAMPLE) && (fill_q >= FILL_W'(CW));
    assign word_ready_o = (state_q == S_SAMPLE) && (fill_q <= FILL_W'(WORD_W))
                          && (wcnt_q < WCNT_W'(NWORDS));
    assign accept       = word_valid_i && word_ready_o;

    // Negative coefficients wrap naturally in 12-bit arithmetic.
    always_comb begin
        a_cnt = '0;
        b_cnt = '0;
        for (int i = 0; i < ETA; i++) begin
            a_cnt = a_cnt + 12'(buf_q[i]);
            b_cnt = b_cnt + 12'(buf_q[ETA + i]);
        end
        coef = a_cnt - b_cnt;
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        wcnt_d    = wcnt_q;
        ccnt_d    = ccnt_q;
        poly_d    = poly_q;
        done_d    = 1'b0;
        buf_shift = buf_q;
        fill_base = fill_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SAMPLE;
                    buf_d   = '0;
                    fill_d  = '0;
                    wcnt_d  = '0;
                    ccnt_d  = '0;
                end
            end
            S_SAMPLE: begin
                if (consume) begin
                    buf_shift = buf_q >> CW;
                    fill_base = fill_q - FILL_W'(CW);
                    poly_d    = {coef, poly_q[255:1]};
                    ccnt_d    = ccnt_q + 8'd1;
                    if (ccnt_q == 8'd255) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // Bits above fill are always zero, so the new word can be ORed in.
                if (accept) begin
                    buf_d  = buf_shift | (BUF_W'(word_i) << fill_base);
                    fill_d = fill_base + FILL_W'(WORD_W);
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end else begin
                    buf_d  = buf_shift;
                    fill_d = fill_base;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            wcnt_q  <= '0;
            ccnt_q  <= '0;
            poly_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            wcnt_q  <= wcnt_d;
            ccnt_q  <= ccnt_d;
            poly_q  <= poly_d;
            done_q  <= done_d;
        end
    end

    assign poly_o = poly_q;
    assign busy_o = (state_q == S_SAMPLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_cbd_sampler.sv
// tb/tb_cbd_sampler.sv - randomized self-checking bench for cbd_sampler (ETA=2 and ETA=3)
module tb_cbd_sampler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start2 = 1'b0, start3 = 1'b0;
    logic valid2 = 1'b0, valid3 = 1'b0;
    logic [63:0] word = '0;
    logic ready2, ready3, busy2, busy3, done2, done3;
    logic [255:0][11:0] poly2, poly3;

    int checks = 0;
    int failures = 0;
    logic [63:0] words[$];

    always #5 clk = ~clk;

    cbd_sampler #(.ETA(2), .WORD_W(64)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .word_i(word),
        .word_valid_i(valid2), .word_ready_o(ready2), .poly_o(poly2),
        .busy_o(busy2), .done_o(done2)
    );

    cbd_sampler #(.ETA(3), .WORD_W(64)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .word_i(word),
        .word_valid_i(valid3), .word_ready_o(ready3), .poly_o(poly3),
        .busy_o(busy3), .done_o(done3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(int p);
        logic [63:0] w;
        w = words[p / 64];
        return w[p % 64];
    endfunction

    // Reference: coefficient i is popcount of its low ETA stream bits minus popcount of the next ETA.
    function automatic logic [11:0] model_coef(int eta, int i);
        int a = 0;
        int b = 0;
        for (int j = 0; j < eta; j++) begin
            a += int'(bit_at(i * 2 * eta + j));
            b += int'(bit_at(i * 2 * eta + eta + j));
        end
        return 12'(a - b);
    endfunction

    function automatic logic [11:0] obs_coef(int eta, int i);
        return (eta == 3) ? poly3[i] : poly2[i];
    endfunction

    task automatic fill_words(input int eta, input logic [63:0] pat, input bit rnd);
        words.delete();
        for (int i = 0; i < 256 * 2 * eta / 64; i++)
            words.push_back(rnd ? {$urandom, $urandom} : pat);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_poly2_zero"}, 32'(poly2 == '0), 1);
        check({tag, "_poly3_zero"}, 32'(poly3 == '0), 1);
        check({tag, "_busy"}, {30'd0, busy2, busy3}, 0);
        check({tag, "_done"}, {30'd0, done2, done3}, 0);
        check({tag, "_ready"}, {30'd0, ready2, ready3}, 0);
    endtask

    task automatic run(input int eta, input int duty, input int abort_k, input int mid_start_k);
        int nw;
        int idx;
        int xfers;
        int k;
        bit seen_done;
        bit busy_ok;
        logic v;
        nw = 256 * 2 * eta / 64;
        idx = 0; xfers = 0; k = 0; seen_done = 0; busy_ok = 1;
        @(negedge clk);
        if (eta == 3) start3 = 1'b1; else start2 = 1'b1;
        while (!seen_done && k < 3000) begin
            @(negedge clk);
            k++;
            start2 = 1'b0;
            start3 = 1'b0;
            if (k == mid_start_k) begin
                if (eta == 3) start3 = 1'b1; else start2 = 1'b1;
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("abort");
                @(negedge clk);
                rst_n = 1'b1;
                valid2 = 1'b0;
                valid3 = 1'b0;
                return;
            end
            if ((eta == 3) ? done3 : done2) begin
                seen_done = 1;
                if (duty == 100) check("latency", k, 258);
            end else begin
                if (!((eta == 3) ? busy3 : busy2)) busy_ok = 0;
                v = ($urandom_range(99) < duty);
                word = (idx < nw) ? words[idx] : {$urandom, $urandom};
                if (eta == 3) valid3 = v; else valid2 = v;
                if (v && ((eta == 3) ? ready3 : ready2)) begin
                    xfers++;
                    idx++;
                end
            end
        end
        check("done_seen", 32'(seen_done), 1);
        check("busy_throughout", 32'(busy_ok), 1);
        check("transfers", xfers, nw);
        if (eta == 3) valid3 = 1'b1; else valid2 = 1'b1;
        @(negedge clk);
        check("done_one_cycle", {31'd0, (eta == 3) ? done3 : done2}, 0);
        check("busy_after_done", {31'd0, (eta == 3) ? busy3 : busy2}, 0);
        check("ready_idle", {31'd0, (eta == 3) ? ready3 : ready2}, 0);
        repeat (3) @(negedge clk);
        valid2 = 1'b0;
        valid3 = 1'b0;
        for (int i = 0; i < 256; i++)
            check($sformatf("coef%0d", i), 32'(obs_coef(eta, i)), 32'(model_coef(eta, i)));
    endtask

    initial begin
        #1;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        fill_words(2, 64'h0, 0);
        run(2, 100, 0, 0);
        check("zero_c0", 32'(poly2[0]), 0);

        fill_words(2, 64'h3333_3333_3333_3333, 0);
        run(2, 100, 0, 0);
        check("p3333_c0", 32'(poly2[0]), 32'h002);
        check("p3333_c255", 32'(poly2[255]), 32'h002);

        fill_words(2, 64'hCCCC_CCCC_CCCC_CCCC, 0);
        run(2, 100, 0, 0);
        check("pCCCC_c7", 32'(poly2[7]), 32'hFFE);

        fill_words(2, 64'h0, 0);
        words[0] = 64'h0000_0000_0000_00C1;
        run(2, 100, 0, 0);
        check("pC1_c0", 32'(poly2[0]), 32'h001);
        check("pC1_c1", 32'(poly2[1]), 32'hFFE);
        check("pC1_c2", 32'(poly2[2]), 0);

        fill_words(3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(3, 100, 0, 0);
        check("e3_ones_c100", 32'(poly3[100]), 0);
        words[0] = 64'hFFFF_FFFF_FFFF_FFC7;
        run(3, 100, 0, 0);
        check("e3_c0", 32'(poly3[0]), 32'h003);

        fill_words(2, 64'h3333_3333_3333_3333, 0);
        run(2, 30, 0, 0);
        check("bp_c200", 32'(poly2[200]), 32'h002);

        fill_words(2, 64'h0, 1);
        run(2, 60, 0, 0);
        fill_words(3, 64'h0, 1);
        run(3, 45, 0, 0);

        fill_words(2, 64'h0, 1);
        run(2, 100, 102, 0);
        fill_words(2, 64'h0, 1);
        run(2, 100, 0, 150);
        fill_words(3, 64'h0, 1);
        run(3, 100, 0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
